roc_arbiter: RTL and testbench

- Two-requester, round-robin controller for the shared roc memory (DW-bit data, AW-bit address, DEP entries, 1-cycle registered read).
- Each requester issues a single read or write with a req/gnt/ack handshake.
- The block serialises the requests onto the memory's single wr/addr/data port and returns read data to the winning requester.
- It sits between the two client blocks and the roc instance.

---
 rtl/roc_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 14 +
 rtl/roc_arbiter.sv | 172 +++++++++++++++++
 tb/tb_roc_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roc_arb_pkg.sv
// Shared constants and FSM encoding for the roc memory round-robin arbiter.
package roc_arb_pkg;

    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned AW_DEF  = 4;
    localparam int unsigned DEP_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; prio names the favoured requester on a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? prio : req[1];
    end

endmodule

// File: rtl/roc_arbiter.sv
// Serialises single read/write commands from two requesters onto the roc memory port,
// granting round-robin and returning read data to the requester that issued the read.
module roc_arbiter
    import roc_arb_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned DEP = DEP_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          valid;
    logic          winner;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // DEP only bounds addresses in the environment; the datapath uses AW directly.
    logic unused_dep;
    assign unused_dep = ^DEP;

    rr_arb2 u_pick (
        .req    ({req1, req0}),
        .prio   (prio_q),
        .valid  (valid),
        .winner (winner)
    );

    always_comb begin
        win_we    = winner ? we1    : we0;
        win_addr  = winner ? addr1  : addr0;
        win_wdata = winner ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = valid ? ISSUE : IDLE;
            ISSUE:   state_d = we_q ? DONE : CAPT;
            CAPT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so each state computes what the next cycle must show.
    always_comb begin
        gnt_d      = 2'b00;
        ack_d      = 2'b00;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        prio_d     = prio_q;
        sel_d      = sel_q;
        we_d       = we_q;
        busy_d     = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    sel_d         = winner;
                    prio_d        = ~winner;
                    we_d          = win_we;
                    gnt_d[winner] = 1'b1;
                    mem_wr_d      = win_we;
                    mem_addr_d    = win_addr;
                    mem_data_d    = win_wdata;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    ack_d[sel_q] = 1'b1;
                end
            end
            CAPT: begin
                ack_d[sel_q] = 1'b1;
                if (sel_q) begin
                    rdata1_d = mem_rdata;
                end else begin
                    rdata0_d = mem_rdata;
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= 1'b0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            gnt_q      <= 2'b00;
            ack_q      <= 2'b00;
            busy_q     <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign ack0     = ack_q[0];
    assign ack1     = ack_q[1];
    assign busy     = busy_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_roc_arbiter.sv
// Bench for roc_arbiter: a memory environment, a cycle-timeline reference model,
// directed scenarios with literal expectations and a randomized two-requester phase.
module tb_roc_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, ack0, ack1, busy, mem_wr;
    logic [7:0] rdata0, rdata1, mem_data, mem_rdata;
    logic [3:0] mem_addr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    roc_arbiter #(.DW(8), .AW(4), .DEP(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .busy      (busy),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: the roc memory, 1-cycle registered read, not cleared by reset.
    bit [7:0] mem [16];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_data;
        mem_rdata <= mem[mem_addr];
    end

    // Reference model: each accepted command follows a fixed timeline from the IDLE
    // decision cycle T: gnt/mem_wr at T+1, ack at T+2 (write) or T+3 (read).
    bit [7:0]   m_mem [16];
    bit         m_active = 1'b0;
    bit         m_prio = 1'b0;
    bit         m_who, m_we;
    int         m_age, m_len;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic [1:0] e_gnt, e_ack;
    logic       e_wr, e_busy;
    logic [3:0] e_addr;
    logic [7:0] e_data, e_rd0, e_rd1;

    always @(posedge clk) begin
        if (m_active && m_age == 1 && m_we) m_mem[m_addr] = m_data;
        if (rst) begin
            m_active = 1'b0; m_prio = 1'b0;
            e_gnt = 2'b00; e_ack = 2'b00; e_wr = 1'b0; e_busy = 1'b0;
            e_addr = '0; e_data = '0; e_rd0 = '0; e_rd1 = '0;
        end else if (!m_active) begin
            e_gnt = 2'b00; e_ack = 2'b00; e_wr = 1'b0; e_busy = 1'b0;
            if (req0 || req1) begin
                m_who    = (req0 && req1) ? m_prio : req1;
                m_prio   = !m_who;
                m_we     = m_who ? we1 : we0;
                m_addr   = m_who ? addr1 : addr0;
                m_data   = m_who ? wdata1 : wdata0;
                m_len    = m_we ? 2 : 3;
                m_age    = 1;
                m_active = 1'b1;
                e_gnt  = m_who ? 2'b10 : 2'b01;
                e_wr   = m_we;
                e_addr = m_addr;
                e_data = m_data;
                e_busy = 1'b1;
            end
        end else if (m_age == m_len) begin
            m_active = 1'b0;
            e_gnt = 2'b00; e_ack = 2'b00; e_wr = 1'b0; e_busy = 1'b0;
        end else begin
            m_age++;
            e_gnt = 2'b00; e_wr = 1'b0; e_busy = 1'b1; e_ack = 2'b00;
            if (m_age == m_len) begin
                e_ack = m_who ? 2'b10 : 2'b01;
                if (!m_we) begin
                    if (m_who) e_rd1 = m_mem[m_addr];
                    else e_rd0 = m_mem[m_addr];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", 32'({gnt1, gnt0}), 32'(e_gnt));
            chk("ack", 32'({ack1, ack0}), 32'(e_ack));
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_data", 32'(mem_data), 32'(e_data));
            chk("rdata0", 32'(rdata0), 32'(e_rd0));
            chk("rdata1", 32'(rdata1), 32'(e_rd1));
        end
    end

    int gq[$];
    always @(negedge clk) begin
        if (gnt0) gq.push_back(0);
        if (gnt1) gq.push_back(1);
    end

    logic       cap_wr;
    logic [3:0] cap_addr;
    logic [7:0] cap_data;

    task automatic drive(input int p, input logic r, input logic w, input logic [3:0] a,
                         input logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? gnt0 : gnt1;
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    // Called at a negedge; returns at the negedge of the ack cycle with req dropped
    // (unless hold), so req is low on the edge that ends the ack cycle.
    task automatic do_op(input int p, input logic w, input logic [3:0] a, input logic [7:0] d,
                         input bit hold, output int lg, output int la, output logic [7:0] rd);
        int start;
        drive(p, 1'b1, w, a, d);
        start = cyc; lg = -1; la = -1; rd = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (gnt_of(p) && lg < 0) begin
                lg = cyc - start;
                cap_wr = mem_wr; cap_addr = mem_addr; cap_data = mem_data;
            end
            if (ack_of(p)) begin
                la = cyc - start;
                rd = (p == 0) ? rdata0 : rdata1;
                break;
            end
        end
        if (!hold) drive(p, 1'b0, w, a, d);
        chk("ack_seen", 32'(la >= 0), 32'd1);
    endtask

    task automatic rand_port(input int p);
        int lg, la;
        logic [7:0] rd, d;
        logic [3:0] a;
        logic w;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            do_op(p, w, a, d, 1'b0, lg, la, rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, required finish before that", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lg, la, lg1, la1, g2;
        logic [7:0] rd, rd1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdata1", 32'(rdata1), 32'd0);
        rst = 1'b0;

        // 1: write then read back from the other requester
        do_op(0, 1'b1, 4'd8, 8'h51, 1'b0, lg, la, rd);
        chk("t1_gnt_lat", 32'(lg), 32'd1);
        chk("t1_mem_wr", 32'(cap_wr), 32'd1);
        chk("t1_mem_addr", 32'(cap_addr), 32'd8);
        chk("t1_mem_data", 32'(cap_data), 32'h51);
        chk("t1_ack_lat", 32'(la), 32'd2);
        @(negedge clk);
        do_op(1, 1'b0, 4'd8, 8'h00, 1'b0, lg, la, rd);
        chk("t1_rd_lat", 32'(la), 32'd3);
        chk("t1_rdata1", 32'(rd), 32'h51);

        // 2: simultaneous writes, requester 0 first
        @(negedge clk);
        gq.delete();
        fork
            do_op(0, 1'b1, 4'd3, 8'hAA, 1'b0, lg, la, rd);
            do_op(1, 1'b1, 4'd4, 8'h55, 1'b0, lg1, la1, rd1);
        join
        chk("t2_order_n", 32'(gq.size()), 32'd2);
        chk("t2_first", 32'(gq[0]), 32'd0);
        chk("t2_ack0_lat", 32'(la), 32'd2);
        chk("t2_gnt1_lat", 32'(lg1), 32'd4);
        chk("t2_ack1_lat", 32'(la1), 32'd5);
        @(negedge clk);
        do_op(0, 1'b0, 4'd3, 8'h00, 1'b0, lg, la, rd);
        chk("t2_rd3", 32'(rd), 32'hAA);
        @(negedge clk);
        do_op(1, 1'b0, 4'd4, 8'h00, 1'b0, lg, la, rd);
        chk("t2_rd4", 32'(rd), 32'h55);

        // 3: four back-to-back reads each, grants must alternate
        @(negedge clk);
        gq.delete();
        fork
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                do_op(0, 1'b0, 4'(i), 8'h00, 1'b0, lg, la, rd);
            end
            for (int j = 0; j < 4; j++) begin
                if (j > 0) @(negedge clk);
                do_op(1, 1'b0, 4'(j + 4), 8'h00, 1'b0, lg1, la1, rd1);
            end
        join
        chk("t3_order_n", 32'(gq.size()), 32'd8);
        for (int k = 0; k < 8 && k < gq.size(); k++) chk("t3_order", 32'(gq[k]), 32'(k % 2));
        chk("t3_busy_last_ack", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t3_busy_after", 32'(busy), 32'd0);

        // 4: boundary addresses
        do_op(0, 1'b1, 4'd15, 8'hFF, 1'b0, lg, la, rd);
        @(negedge clk);
        do_op(0, 1'b1, 4'd0, 8'h01, 1'b0, lg, la, rd);
        @(negedge clk);
        do_op(0, 1'b0, 4'd15, 8'h00, 1'b0, lg, la, rd);
        chk("t4_rd15", 32'(rd), 32'hFF);
        @(negedge clk);
        do_op(1, 1'b0, 4'd0, 8'h00, 1'b0, lg, la, rd);
        chk("t4_rd0", 32'(rd), 32'h01);

        // 5: reset during the capture cycle of a read by requester 1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1'b1, 1'b0, 4'd8, 8'h00);
        @(negedge clk);
        chk("t5_gnt1", 32'(gnt1), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 4'd8, 8'h00);
        @(negedge clk);
        chk("t5_outs_zero", 32'({gnt0, gnt1, ack0, ack1, busy, mem_wr}), 32'd0);
        chk("t5_addr_data", 32'({mem_addr, mem_data}), 32'd0);
        chk("t5_rdata1", 32'(rdata1), 32'd0);
        rst = 1'b0;
        do_op(1, 1'b0, 4'd8, 8'h00, 1'b0, lg, la, rd);
        chk("t5_rd_lat", 32'(la), 32'd3);
        chk("t5_rdata1_after", 32'(rd), 32'h51);

        // 6: req held through ack is a new request
        @(negedge clk);
        do_op(0, 1'b1, 4'd5, 8'h33, 1'b1, lg, la, rd);
        chk("t6_ack_lat", 32'(la), 32'd2);
        g2 = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (gnt0) begin
                g2 = n;
                break;
            end
        end
        chk("t6_regrant", 32'(g2), 32'd2);
        la = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack0) begin
                la = n;
                break;
            end
        end
        drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("t6_second_ack", 32'(la), 32'd1);

        // Randomized contention, checked by the model every cycle
        @(negedge clk);
        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
